// File: rtl/operand_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// operand_fetch_ctrl_if : start/memory/operand-pair bus of operand_fetch_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface operand_fetch_ctrl_if #(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_ADDR = 8
);
  logic                 i_start;
  logic [SIZE_ADDR-1:0] i_base_addr;
  logic [SIZE_ADDR-1:0] i_num_pairs;
  logic [SIZE_ADDR-1:0] o_mem_addr;
  logic                 o_mem_rd_en;
  logic [SIZE_DATA-1:0] i_mem_data;
  logic [SIZE_DATA-1:0] o_data_a;
  logic [SIZE_DATA-1:0] o_data_b;
  logic                 o_valid;
  logic                 i_ready;
  logic                 o_busy;
  logic                 o_done;

  // master is the fetch controller, slave is the requester/memory/consumer side
  modport master (
    input  i_start, i_base_addr, i_num_pairs, i_mem_data, i_ready,
    output o_mem_addr, o_mem_rd_en, o_data_a, o_data_b, o_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_base_addr, i_num_pairs, i_mem_data, i_ready,
    input  o_mem_addr, o_mem_rd_en, o_data_a, o_data_b, o_valid, o_busy, o_done
  );
endinterface

`default_nettype wire

// File: rtl/operand_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// operand_fetch_ctrl : fetches A/B operand pairs from consecutive memory words
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module operand_fetch_ctrl #(
  parameter int SIZE_DATA = 8,
  parameter int SIZE_ADDR = 8
) (
  input  wire logic          i_clk,
  input  wire logic          i_rst_n,
  operand_fetch_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH_A = 3'd1;
  localparam logic [2:0] S_FETCH_B = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [SIZE_ADDR-1:0] c_ONE = SIZE_ADDR'(1);

  logic [2:0]           state_q, state_d;
  logic [SIZE_ADDR-1:0] ptr_q, ptr_d;
  logic [SIZE_ADDR-1:0] remaining_q, remaining_d;
  logic [SIZE_ADDR-1:0] addr_q, addr_d;
  logic [SIZE_DATA-1:0] data_a_q, data_a_d;
  logic [SIZE_DATA-1:0] data_b_q, data_b_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      addr_q      <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      addr_q      <= addr_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    addr_d      = addr_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          ptr_d       = bus.i_base_addr;
          remaining_d = bus.i_num_pairs;
          state_d     = (bus.i_num_pairs == '0) ? S_DONE : S_FETCH_A;
        end
      end
      S_FETCH_A: begin
        addr_d  = ptr_q;
        ptr_d   = ptr_q + c_ONE;
        state_d = S_FETCH_B;
      end
      S_FETCH_B: begin
        // word read in FETCH_A arrives now
        addr_d   = ptr_q;
        data_a_d = bus.i_mem_data;
        ptr_d    = ptr_q + c_ONE;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        data_b_d = bus.i_mem_data;
        state_d  = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.i_ready) begin
          remaining_d = remaining_q - c_ONE;
          state_d     = (remaining_q == c_ONE) ? S_DONE : S_FETCH_A;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // addr_q remembers the last issued address so the bus holds it between reads
  always_comb begin
    bus.o_mem_rd_en = (state_q == S_FETCH_A) || (state_q == S_FETCH_B);
    bus.o_mem_addr  = bus.o_mem_rd_en ? ptr_q : addr_q;
    bus.o_data_a    = data_a_q;
    bus.o_data_b    = data_b_q;
    bus.o_valid     = (state_q == S_OUTPUT);
    bus.o_busy      = (state_q != S_IDLE);
    bus.o_done      = (state_q == S_DONE);
  end

endmodule

`default_nettype wire

// File: tb/tb_operand_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_operand_fetch_ctrl : randomized bench with a cycle-schedule reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_operand_fetch_ctrl;

  logic clk;
  logic rst_n;

  operand_fetch_ctrl_if #(.SIZE_DATA(8), .SIZE_ADDR(8)) bus ();

  operand_fetch_ctrl #(.SIZE_DATA(8), .SIZE_ADDR(8)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [256];

  // read data is only meaningful the cycle after a read; otherwise garbage
  always @(posedge clk) begin
    if (bus.o_mem_rd_en) bus.i_mem_data <= mem[bus.o_mem_addr];
    else                 bus.i_mem_data <= 8'($urandom);
  end

  typedef struct {
    bit       rd;
    bit [7:0] addr;
    bit       valid;
    bit [7:0] a;
    bit [7:0] b;
    bit       done;
    bit       busy;
    bit       ready;
    bit       idle;
  } rec_t;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00, last_addr = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_rec(input int i, input rec_t r);
    check_val($sformatf("rd_en[%0d]", i), 32'(bus.o_mem_rd_en), 32'(r.rd));
    check_val($sformatf("addr[%0d]",  i), 32'(bus.o_mem_addr),  32'(r.addr));
    check_val($sformatf("valid[%0d]", i), 32'(bus.o_valid),     32'(r.valid));
    check_val($sformatf("data_a[%0d]",i), 32'(bus.o_data_a),    32'(r.a));
    check_val($sformatf("data_b[%0d]",i), 32'(bus.o_data_b),    32'(r.b));
    check_val($sformatf("done[%0d]",  i), 32'(bus.o_done),      32'(r.done));
    check_val($sformatf("busy[%0d]",  i), 32'(bus.o_busy),      32'(r.busy));
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd_en"}, 32'(bus.o_mem_rd_en), 32'd0);
    check_val({tag, "_addr"},  32'(bus.o_mem_addr),  32'd0);
    check_val({tag, "_valid"}, 32'(bus.o_valid),     32'd0);
    check_val({tag, "_a"},     32'(bus.o_data_a),    32'd0);
    check_val({tag, "_b"},     32'(bus.o_data_b),    32'd0);
    check_val({tag, "_done"},  32'(bus.o_done),      32'd0);
    check_val({tag, "_busy"},  32'(bus.o_busy),      32'd0);
  endtask

  // Called at a negedge with the DUT idle. Builds the expected per-cycle
  // schedule of the whole transaction, then steps it one cycle at a time.
  task automatic run_txn(input logic [7:0] base, input logic [7:0] num,
                         input int stall_lo, input int stall_hi, input int abort_idx);
    rec_t q[$];
    rec_t r;
    logic [7:0] p, la, lb, ad, pa, pb;
    int s;
    p = base; la = last_a; lb = last_b; ad = last_addr;
    for (int k = 0; k < int'(num); k++) begin
      r = '{rd:1, addr:p, valid:0, a:la, b:lb, done:0, busy:1, ready:1'($urandom), idle:0};
      q.push_back(r);
      pa = mem[p]; p = p + 8'd1; ad = p; pb = mem[p];
      r.addr = p; r.ready = 1'($urandom);
      q.push_back(r);
      p = p + 8'd1; la = pa;
      r = '{rd:0, addr:ad, valid:0, a:la, b:lb, done:0, busy:1, ready:1'($urandom), idle:0};
      q.push_back(r);
      lb = pb;
      s = $urandom_range(stall_hi, stall_lo);
      for (int w = 0; w <= s; w++) begin
        r = '{rd:0, addr:ad, valid:1, a:la, b:lb, done:0, busy:1, ready:(w == s), idle:0};
        q.push_back(r);
      end
    end
    r = '{rd:0, addr:ad, valid:0, a:la, b:lb, done:1, busy:1, ready:1'($urandom), idle:0};
    q.push_back(r);
    r.done = 0; r.busy = 0; r.idle = 1;
    q.push_back(r);

    bus.i_start = 1'b1; bus.i_base_addr = base; bus.i_num_pairs = num;
    bus.i_ready = 1'($urandom);
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      check_rec(i, q[i]);
      if (i == abort_idx) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_async");
        bus.i_start = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_val("rst_hold_done", 32'(bus.o_done), 32'd0);
          check_val("rst_hold_busy", 32'(bus.o_busy), 32'd0);
        end
        rst_n = 1'b1;
        last_a = 8'h00; last_b = 8'h00; last_addr = 8'h00;
        return;
      end
      bus.i_ready     = q[i].ready;
      bus.i_start     = q[i].idle ? 1'b0 : 1'($urandom);
      bus.i_base_addr = 8'($urandom);
      bus.i_num_pairs = 8'($urandom);
    end
    last_a = la; last_b = lb; last_addr = ad;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_base_addr = '0; bus.i_num_pairs = '0; bus.i_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hAA;
    mem[8'h11] = 8'h55;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    run_txn(8'h10, 8'd1, 0, 0, -1);
    check_val("req33_a", 32'(last_a), 32'hAA);
    check_val("req33_b", 32'(last_b), 32'h55);
    run_txn(8'h20, 8'd3, 0, 0, -1);
    run_txn(8'h40, 8'd1, 5, 5, -1);
    run_txn(8'hFF, 8'd1, 0, 0, -1);
    run_txn(8'h50, 8'd0, 0, 0, -1);
    run_txn(8'h60, 8'd3, 0, 0, 5);
    run_txn(8'h80, 8'd2, 0, 1, -1);

    for (int t = 0; t < 25; t++)
      run_txn(8'($urandom), 8'($urandom_range(4, 0)), 0, 3, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/operand_fetch_ctrl.md
OPERAND_FETCH_CTRL -- requirements
Module: operand_fetch_ctrl

Interface
REQ-001 Parameter SIZE_DATA, default 8, operand and memory data width in bits.
REQ-002 Parameter SIZE_ADDR, default 8, memory address width and pair-count width in bits.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  start request; sampled only in IDLE.
REQ-006 i_base_addr  input  SIZE_ADDR  address of first operand; latched on accepted start.
REQ-007 i_num_pairs  input  SIZE_ADDR  number of A/B pairs to fetch; latched on accepted start.
REQ-008 o_mem_addr  output  SIZE_ADDR  memory read address.
REQ-009 o_mem_rd_en  output  1  memory read enable.
REQ-010 i_mem_data  input  SIZE_DATA  read data; valid exactly one cycle after the cycle o_mem_rd_en is high.
REQ-011 o_data_a  output  SIZE_DATA  operand A (even-offset word of pair).
REQ-012 o_data_b  output  SIZE_DATA  operand B (odd-offset word of pair).
REQ-013 o_valid  output  1  o_data_a/o_data_b hold a pair not yet accepted.
REQ-014 i_ready  input  1  consumer accepts pair when o_valid and i_ready are both high at a rising edge.
REQ-015 o_busy  output  1  high in every state except IDLE.
REQ-016 o_done  output  1  one-cycle pulse after final pair accepted.

Function
REQ-017 FSM states SHALL be IDLE, FETCH_A, FETCH_B, CAPTURE, OUTPUT, DONE; all outputs decoded from registers, no input-to-output combinational path.
REQ-018 IDLE: i_start=1 -> latch ptr=i_base_addr, remaining=i_num_pairs; remaining==0 -> DONE, else -> FETCH_A.
REQ-019 FETCH_A: o_mem_rd_en=1, o_mem_addr=ptr; ptr+=1; -> FETCH_B.
REQ-020 FETCH_B: o_mem_rd_en=1, o_mem_addr=ptr; capture i_mem_data into o_data_a at edge; ptr+=1; -> CAPTURE.
REQ-021 CAPTURE: o_mem_rd_en=0; capture i_mem_data into o_data_b at edge; -> OUTPUT.
REQ-022 OUTPUT: o_valid=1; o_data_a/o_data_b stable until handshake; on handshake remaining-=1; remaining becomes 0 -> DONE, else -> FETCH_A; no handshake -> stay.
REQ-023 DONE: o_done=1 for exactly one cycle; -> IDLE.
REQ-024 o_mem_rd_en SHALL be high only in FETCH_A and FETCH_B; o_mem_addr holds last value otherwise.
REQ-025 Latency: o_valid rises at the 4th rising edge counting the edge that samples i_start (start edge -> FETCH_A -> FETCH_B -> CAPTURE -> OUTPUT); with i_ready held high, one pair per 4 cycles.
REQ-026 ptr arithmetic modulo 2^SIZE_ADDR; address wraps from max to 0 without error.
REQ-027 i_start while not IDLE SHALL be ignored; i_base_addr/i_num_pairs changes after latch SHALL have no effect.
REQ-028 i_start in DONE ignored; accepted only once back in IDLE (next cycle).
REQ-029 o_data_a/o_data_b SHALL retain last captured values after DONE until the next capture.
REQ-030 i_ready while o_valid=0 SHALL have no effect.

Reset
REQ-031 i_rst_n low SHALL immediately force IDLE, ptr=0, remaining=0, o_mem_addr=0, o_mem_rd_en=0, o_data_a=0, o_data_b=0, o_valid=0, o_busy=0, o_done=0.
REQ-032 Reset mid-operation SHALL abandon the sequence without an o_done pulse; first start after release begins a fresh sequence.

Verification
REQ-033 Base=0x10, num=1, i_ready=1, mem[0x10]=0xAA, mem[0x11]=0x55 -> rd_en at 0x10, 0x11 on consecutive cycles; o_valid at 4th edge with A=0xAA, B=0x55; o_done pulse 1 cycle later.
REQ-034 Base=0x20, num=3, i_ready=1 -> 6 reads at 0x20..0x25, 3 handshakes 4 cycles apart, single o_done after third.
REQ-035 num=1, i_ready held low 5 cycles in OUTPUT -> o_valid and data stable 5 cycles, no new reads, handshake on ready rise.
REQ-036 Base=0xFF, num=1 -> addresses 0xFF then 0x00.
REQ-037 num=0 -> no rd_en, o_done one cycle after start edge, o_busy high 1 cycle; i_start during busy ignored.
REQ-038 Reset asserted in FETCH_B of pair 2 of 3 -> all outputs zero immediately, no o_done; new start after release reads from new base.
